wm_sequencer: RTL and testbench

- Master sequencing FSM of the washing-machine controller.
- Drives the 3-bit `state` bus consumed by the phase timer.
- Consumes the timer's phase-completion flags (`sig_Full`, `sig_Temperature`, `sig_Wash_Completed`, `sig_Rinse_Completed`, `sig_Spin_Completed`) and decodes actuator enables from its state.
- Adds an abort path, a door interlock and a per-phase watchdog that raises a sticky fault.

---
 rtl/wm_pkg.sv | 32 +++
 rtl/wm_sequencer_if.sv | 40 ++++
 rtl/wm_watchdog.sv | 39 +++
 rtl/wm_sequencer.sv | 103 ++++++++++
 tb/tb_wm_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine sequencer and its phase timer.
// The state encoding is consumed directly by the timer, so it must not change.
package wm_pkg;

  typedef enum logic [2:0] {
    START      = 3'd0,
    READY      = 3'd1,
    FILL_WATER = 3'd2,
    HEAT_WATER = 3'd3,
    WASH       = 3'd4,
    RINSE      = 3'd5,
    SPIN       = 3'd6,
    DONE       = 3'd7
  } state_e;

  // Door-locked range: abort and door-open are honoured only inside it
  localparam state_e FIRST_ACTIVE = READY;
  localparam state_e LAST_ACTIVE  = SPIN;

  // Timed range: phases waiting on a timer flag, supervised by the watchdog
  localparam state_e FIRST_TIMED  = FILL_WATER;
  localparam state_e LAST_TIMED   = SPIN;

  function automatic logic is_active(input state_e s);
    return (s >= FIRST_ACTIVE) && (s <= LAST_ACTIVE);
  endfunction

  function automatic logic is_timed(input state_e s);
    return (s >= FIRST_TIMED) && (s <= LAST_TIMED);
  endfunction

endpackage

// File: rtl/wm_sequencer_if.sv
// Bundle of user requests, timer flags and actuator enables around the sequencer.
// The master side is the sequencer; the slave side is the timer/panel/actuators.
interface wm_sequencer_if;
  import wm_pkg::*;

  logic   start_req;
  logic   abort_req;
  logic   door_closed;
  logic   sig_Full;
  logic   sig_Temperature;
  logic   sig_Wash_Completed;
  logic   sig_Rinse_Completed;
  logic   sig_Spin_Completed;
  state_e state;
  logic   water_valve;
  logic   heater;
  logic   motor_wash;
  logic   motor_spin;
  logic   drain_valve;
  logic   door_lock;
  logic   done;
  logic   fault;

  modport master (
    input  start_req, abort_req, door_closed,
    input  sig_Full, sig_Temperature, sig_Wash_Completed,
    input  sig_Rinse_Completed, sig_Spin_Completed,
    output state, water_valve, heater, motor_wash, motor_spin,
    output drain_valve, door_lock, done, fault
  );

  modport slave (
    output start_req, abort_req, door_closed,
    output sig_Full, sig_Temperature, sig_Wash_Completed,
    output sig_Rinse_Completed, sig_Spin_Completed,
    input  state, water_valve, heater, motor_wash, motor_spin,
    input  drain_valve, door_lock, done, fault
  );

endinterface

// File: rtl/wm_watchdog.sv
// Per-phase cycle counter. Cleared on every phase change or when idle,
// saturates instead of wrapping, and flags the last allowed cycle of a phase.
// WDOG_WIDTH must be wide enough that TIMEOUT_CYCLES-1 is representable.
module wm_watchdog #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int WDOG_WIDTH     = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [WDOG_WIDTH-1:0] count_q;
  logic [WDOG_WIDTH-1:0] count_d;

  // Next count: zero when cleared or idle, otherwise step up and hold at all-ones
  always_comb begin
    count_d = count_q;
    if (clear || !enable) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + WDOG_WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == WDOG_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wm_sequencer.sv
// Master sequencing FSM of the washing-machine controller. Moore machine:
// actuator enables decode from the registered state only.
module wm_sequencer
  import wm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int WDOG_WIDTH     = 5
) (
  input logic            clock,
  input logic            reset,
  wm_sequencer_if.master bus
);

  state_e state_q;
  state_e state_d;
  logic   fault_q;
  logic   fault_d;
  logic   phase_flag;
  logic   wdog_expired;
  logic   wdog_clear;
  logic   wdog_enable;

  assign wdog_clear  = (state_d != state_q);
  assign wdog_enable = is_timed(state_q);

  wm_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .WDOG_WIDTH     (WDOG_WIDTH)
  ) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wdog_clear),
    .enable  (wdog_enable),
    .expired (wdog_expired)
  );

  // Pick the completion flag of the current phase only; stale flags are ignored
  always_comb begin
    phase_flag = 1'b0;
    case (state_q)
      FILL_WATER: phase_flag = bus.sig_Full;
      HEAT_WATER: phase_flag = bus.sig_Temperature;
      WASH:       phase_flag = bus.sig_Wash_Completed;
      RINSE:      phase_flag = bus.sig_Rinse_Completed;
      SPIN:       phase_flag = bus.sig_Spin_Completed;
      default:    phase_flag = 1'b0;
    endcase
  end

  // Next state and fault: abort/door first, then watchdog, then phase progression
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    if (is_active(state_q) && (bus.abort_req || !bus.door_closed)) begin
      state_d = START;
      if (!bus.door_closed) begin
        fault_d = 1'b1;
      end
    end else if (wdog_expired && !phase_flag) begin
      state_d = START;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        START: begin
          if (bus.start_req && bus.door_closed) begin
            state_d = READY;
            fault_d = 1'b0;
          end
        end
        READY:      state_d = FILL_WATER;
        FILL_WATER: if (phase_flag) state_d = HEAT_WATER;
        HEAT_WATER: if (phase_flag) state_d = WASH;
        WASH:       if (phase_flag) state_d = RINSE;
        RINSE:      if (phase_flag) state_d = SPIN;
        SPIN:       if (phase_flag) state_d = DONE;
        DONE:       if (!bus.start_req) state_d = START;
        default:    state_d = START;
      endcase
    end
  end

  // State and sticky fault registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= START;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.water_valve = (state_q == FILL_WATER) || (state_q == RINSE);
  assign bus.heater      = (state_q == HEAT_WATER);
  assign bus.motor_wash  = (state_q == WASH) || (state_q == RINSE);
  assign bus.motor_spin  = (state_q == SPIN);
  assign bus.drain_valve = (state_q == SPIN);
  assign bus.door_lock   = is_active(state_q);
  assign bus.done        = (state_q == DONE);
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_wm_sequencer.sv
// Directed bench for wm_sequencer: full cycle, watchdog, door open,
// abort racing a flag, stale flags and reset in the middle of a phase.
module tb_wm_sequencer;

  localparam logic [4:0] F_FULL  = 5'b00001;
  localparam logic [4:0] F_TEMP  = 5'b00010;
  localparam logic [4:0] F_WASH  = 5'b00100;
  localparam logic [4:0] F_RINSE = 5'b01000;
  localparam logic [4:0] F_SPIN  = 5'b10000;

  logic clock;
  logic reset;
  int   total_checks;
  int   bad_checks;
  logic exp_fault;

  wm_sequencer_if bus ();

  wm_sequencer #(
    .TIMEOUT_CYCLES (16),
    .WDOG_WIDTH     (5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected {water, heater, motor_wash, motor_spin, drain, lock, done} per state
  function automatic logic [6:0] exp_outputs(input int s);
    logic w, h, mw, ms, dr, lk, dn;
    w  = (s == 2) || (s == 5);
    h  = (s == 3);
    mw = (s == 4) || (s == 5);
    ms = (s == 6);
    dr = (s == 6);
    lk = (s >= 1) && (s <= 6);
    dn = (s == 7);
    return {w, h, mw, ms, dr, lk, dn};
  endfunction

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total_checks++;
    if (actual != expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive inputs, advance one clock edge, then settle just past the edge
  task automatic applyStimulus(input logic st, input logic ab, input logic dr, input logic [4:0] fl);
    bus.start_req           = st;
    bus.abort_req           = ab;
    bus.door_closed         = dr;
    bus.sig_Full            = fl[0];
    bus.sig_Temperature     = fl[1];
    bus.sig_Wash_Completed  = fl[2];
    bus.sig_Rinse_Completed = fl[3];
    bus.sig_Spin_Completed  = fl[4];
    @(posedge clock);
    #1;
  endtask

  task automatic checkState(input string tag, input int exp_state);
    logic [6:0] obs;
    obs = {bus.water_valve, bus.heater, bus.motor_wash, bus.motor_spin,
           bus.drain_valve, bus.door_lock, bus.done};
    checkOutput({tag, "_state"}, int'(bus.state), exp_state);
    checkOutput({tag, "_outs"}, int'(obs), int'(exp_outputs(exp_state)));
    checkOutput({tag, "_fault"}, int'(bus.fault), int'(exp_fault));
    checkOutput({tag, "_mutex"},
                int'((bus.heater & bus.motor_spin) | (bus.water_valve & bus.drain_valve)), 0);
  endtask

  // Two idle cycles in a phase, then its flag on the third
  task automatic runPhase(input string tag, input int st, input logic [4:0] flag);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b0);
    checkState({tag, "_wait1"}, st);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b0);
    checkState({tag, "_wait2"}, st);
    applyStimulus(1'b0, 1'b0, 1'b1, flag);
    checkState({tag, "_adv"}, st + 1);
  endtask

  initial begin
    total_checks = 0;
    bad_checks   = 0;
    exp_fault    = 1'b0;
    reset        = 1'b1;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b1, 5'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'b0);
    checkState("reset", 0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b0);
    checkState("idle", 0);

    // Full cycle with flags 3 cycles into each phase
    $display("[TB] full cycle");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'b0);
    checkState("fc_ready", 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'b0);
    checkState("fc_fill", 2);
    runPhase("fc_fill", 2, F_FULL);
    runPhase("fc_heat", 3, F_TEMP);
    runPhase("fc_wash", 4, F_WASH);
    runPhase("fc_rinse", 5, F_RINSE);
    runPhase("fc_spin", 6, F_SPIN);
    applyStimulus(1'b1, 1'b1, 1'b0, 5'b0);
    checkState("fc_done_hold", 7);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b0);
    checkState("fc_back_start", 0);

    // Watchdog: HEAT_WATER lasts exactly 16 cycles without sig_Temperature
    $display("[TB] watchdog");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'b0);
    checkState("wd_ready", 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b0);
    checkState("wd_fill", 2);
    applyStimulus(1'b0, 1'b0, 1'b1, F_FULL);
    checkState("wd_heat1", 3);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 5'b0);
      checkState("wd_heat_hold", 3);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b0);
    exp_fault = 1'b1;
    checkState("wd_expired", 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b0);
    checkState("wd_sticky", 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 5'b0);
    exp_fault = 1'b0;
    checkState("wd_restart", 1);

    // Door opened in WASH
    $display("[TB] door open");
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, F_FULL);
    applyStimulus(1'b0, 1'b0, 1'b1, F_TEMP);
    checkState("door_wash", 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'b0);
    exp_fault = 1'b1;
    checkState("door_open", 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 5'b0);
    checkState("door_blocks_start", 0);

    // Abort together with the rinse flag
    $display("[TB] abort vs flag");
    applyStimulus(1'b1, 1'b0, 1'b1, 5'b0);
    exp_fault = 1'b0;
    checkState("ab_ready", 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, F_FULL);
    applyStimulus(1'b0, 1'b0, 1'b1, F_TEMP);
    applyStimulus(1'b0, 1'b0, 1'b1, F_WASH);
    checkState("ab_rinse", 5);
    applyStimulus(1'b0, 1'b1, 1'b1, F_RINSE);
    checkState("ab_abort", 0);

    // Stale sig_Full held high throughout
    $display("[TB] stale flag");
    applyStimulus(1'b1, 1'b0, 1'b1, F_FULL);
    checkState("st_ready", 1);
    applyStimulus(1'b0, 1'b0, 1'b1, F_FULL);
    checkState("st_ready_one_cycle", 2);
    applyStimulus(1'b0, 1'b0, 1'b1, F_FULL);
    checkState("st_heat", 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, F_FULL);
      checkState("st_heat_wait", 3);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, F_FULL | F_TEMP);
    checkState("st_wash", 4);
    applyStimulus(1'b0, 1'b0, 1'b1, F_FULL | F_TEMP | F_RINSE);
    checkState("st_wash_wait", 4);
    applyStimulus(1'b0, 1'b0, 1'b1, F_FULL | F_TEMP | F_WASH);
    checkState("st_rinse", 5);
    applyStimulus(1'b0, 1'b0, 1'b1, F_RINSE);
    checkState("st_spin", 6);

    // Reset in the middle of SPIN
    $display("[TB] reset mid-spin");
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 5'b0);
    checkState("rst_spin", 0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 5'b0);
    checkState("rst_release_ready", 1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
